// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO stage speaking the uc/cu/cd/dc flag protocol on both sides.
// Define STREAM_FIFO_PKT_EN for store-and-forward packet mode (frame counter gates downstream V).
module stream_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           uc_d0,
    input  logic [3:0]             uc_mflags,
    output logic [1:0]             cu_sflags,
    output logic [W-1:0]           cd_d0,
    output logic [3:0]             cd_mflags,
    input  logic [1:0]             dc_sflags,
    output logic [$clog2(DEPTH):0] lvl
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    // Entry layout: {A, F, L, data}; V is regenerated from occupancy.
    logic [W+2:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W+2:0]  head;
    logic          full, out_v, push, pop;
    logic          unused_ok;

    assign unused_ok = dc_sflags[1];
    assign full      = (cnt_q == FULL_CNT);
    assign head      = mem_q[rd_ptr_q];

`ifdef STREAM_FIFO_PKT_EN
    logic [AW:0] fcnt_q, fcnt_d;
    // Full override lets frames longer than DEPTH cut through instead of deadlocking.
    assign out_v = (cnt_q != '0) && ((fcnt_q != '0) || full);

    always_comb begin
        fcnt_d = fcnt_q;
        case ({push && uc_mflags[1], pop && head[W]})
            2'b10:   fcnt_d = fcnt_q + ONE_CNT;
            2'b01:   fcnt_d = fcnt_q - ONE_CNT;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end
`else
    assign out_v = (cnt_q != '0);
`endif

    assign push = uc_mflags[0] && !full;
    assign pop  = out_v && !dc_sflags[0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + ONE_CNT;
            2'b01:   cnt_d = cnt_q - ONE_CNT;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: V gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {uc_mflags[3:1], uc_d0};
    end

    assign cu_sflags = {1'b0, full};
    assign cd_mflags = out_v ? {head[W+2:W], 1'b1} : 4'b0000;
    assign cd_d0     = out_v ? head[W-1:0] : '0;
    assign lvl       = cnt_q;
endmodule

// File: tb/tb_stream_fifo.sv
// Randomized bench for stream_fifo: queue-based reference model checked every cycle,
// plus literal expectations for latency, back-pressure, reset and packet mode.
module tb_stream_fifo;
    localparam int W = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] uc_d0;
    logic [3:0]   uc_mflags;
    logic [1:0]   cu_sflags;
    logic [W-1:0] cd_d0;
    logic [3:0]   cd_mflags;
    logic [1:0]   dc_sflags;
    logic [2:0]   lvl;

    typedef logic [W+2:0] ent_t;   // {A, F, L, data}

    ent_t m_q[$];
    int   m_fr;
    ent_t src_q[$];
    ent_t rcv_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   cmp_en = 1'b0;

    stream_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .uc_d0(uc_d0), .uc_mflags(uc_mflags),
        .cu_sflags(cu_sflags), .cd_d0(cd_d0), .cd_mflags(cd_mflags),
        .dc_sflags(dc_sflags), .lvl(lvl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_v();
        bit v;
        v = (m_q.size() != 0);
`ifdef STREAM_FIFO_PKT_EN
        v = v && ((m_fr != 0) || (m_q.size() == DEPTH));
`endif
        return v;
    endfunction

    // Reference model: a queue of held words plus a count of held frame ends.
    initial forever begin
        bit full, pop, push;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_fr = 0;
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = model_v() && !dc_sflags[0];
            push = uc_mflags[0] && !full;
            if (pop) begin
                if (m_q[0][W]) m_fr--;
                void'(m_q.pop_front());
            end
            if (push) begin
                m_q.push_back({uc_mflags[3:1], uc_d0});
                if (uc_mflags[1]) m_fr++;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        bit   v;
        ent_t h;
        @(negedge clk);
        if (cmp_en) begin
            v = model_v();
            h = v ? m_q[0] : '0;
            chk("cd_mflags", cd_mflags, v ? {h[W+2:W], 1'b1} : 4'b0);
            chk("cd_d0", cd_d0, v ? h[W-1:0] : '0);
            chk("lvl", lvl, m_q.size());
            chk("cu_sflags", cu_sflags, {1'b0, m_q.size() == DEPTH});
        end
    end

    // Record every word the consumer takes.
    initial forever begin
        @(negedge clk);
        if (rst_n && cd_mflags[0] && !dc_sflags[0]) rcv_q.push_back({cd_mflags[3:1], cd_d0});
    end

    function automatic logic dc_bsy(input int mode, input int cyc);
        case (mode)
            2:       return (cyc % 12) >= 10;
            3:       return $urandom_range(99) < 30;
            default: return 1'b0;
        endcase
    endfunction

    // Offer src_q upstream (honouring cu BSY) until every word has come out downstream.
    task automatic run_stream(input int mode, input int gap_pct, input int budget,
                              output int mx, output int gaps);
        int idx = 0;
        int cyc = 0;
        bit acc;
        mx = 0;
        gaps = 0;
        rcv_q.delete();
        while (rcv_q.size() < src_q.size() && cyc < budget) begin
            if (idx < src_q.size() && $urandom_range(99) >= gap_pct) begin
                uc_d0     = src_q[idx][W-1:0];
                uc_mflags = {src_q[idx][W+2:W], 1'b1};
            end else begin
                uc_d0     = W'($urandom);
                uc_mflags = {3'($urandom), 1'b0};
            end
            dc_sflags = {1'($urandom), dc_bsy(mode, cyc)};
            @(negedge clk);
            #1;
            acc = uc_mflags[0] && !cu_sflags[0];
            if (int'(lvl) > mx) mx = int'(lvl);
            if (rcv_q.size() > 0 && rcv_q.size() < src_q.size() && !cd_mflags[0]) gaps++;
            step();
            if (acc) idx++;
            cyc++;
        end
        uc_mflags = 4'b0;
        dc_sflags = 2'b00;
        if (cyc >= budget) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d of %0d words", rcv_q.size(), src_q.size());
        end
        chk("rcv_count", rcv_q.size(), src_q.size());
        foreach (src_q[i]) if (i < rcv_q.size()) chk("rcv_word", rcv_q[i], src_q[i]);
    endtask

    initial begin
        int mx, gaps;
        uc_d0 = '0;
        uc_mflags = 4'b0;
        dc_sflags = 2'b00;

        #3;
        chk("rst_cd_mflags", cd_mflags, 4'b0);
        chk("rst_cd_d0", cd_d0, 16'h0);
        chk("rst_lvl", lvl, 3'd0);
        chk("rst_cu_sflags", cu_sflags, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        // Latency: no bypass, word visible the cycle after the push.
        uc_d0 = 16'h00AA;
        uc_mflags = 4'b0111;
        @(negedge clk);
        chk("nobypass_v", cd_mflags[0], 1'b0);
        step();
        uc_mflags = 4'b0;
        @(negedge clk);
        chk("lat_mflags", cd_mflags, 4'b0111);
        chk("lat_d0", cd_d0, 16'h00AA);
        chk("lat_lvl", lvl, 3'd1);
        step();
        @(negedge clk);
        chk("pop_lvl", lvl, 3'd0);
        chk("pop_mflags", cd_mflags, 4'b0);

        // Fill and back-pressure.
        step();
        dc_sflags = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            uc_d0 = W'(i);
            uc_mflags = {1'b0, i == 1, 1'b0, 1'b1};
            step();
        end
        uc_d0 = 16'd5;
        uc_mflags = 4'b0011;
        @(negedge clk);
        chk("full_bsy", cu_sflags, 2'b01);
        chk("full_lvl", lvl, 3'd4);
        step();
        step();
        @(negedge clk);
        chk("held_lvl", lvl, 3'd4);
        chk("held_d0", cd_d0, 16'd1);
        step();
        rcv_q.delete();
        dc_sflags = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
`ifndef STREAM_FIFO_PKT_EN
            chk("drain_d0", cd_d0, k);
            chk("drain_v", cd_mflags[0], 1'b1);
`endif
            if (k == 2) chk("bsy_clear", cu_sflags, 2'b00);
            step();
            if (k == 2) uc_mflags = 4'b0;
        end
        repeat (4) step();
        chk("drain_count", rcv_q.size(), 5);
        foreach (rcv_q[i]) chk("drain_word", rcv_q[i][W-1:0], i + 1);

        // Streaming 1..20, consumer never busy.
        src_q.delete();
        for (int i = 1; i <= 20; i++) src_q.push_back({1'b0, i == 1, i == 20, W'(i)});
        run_stream(0, 0, 200, mx, gaps);
`ifndef STREAM_FIFO_PKT_EN
        chk("stream_lvl_le1", mx <= 1, 1'b1);
        chk("stream_gaps", gaps, 0);
`endif

        // Bursty consumer: 10 cycles ready, 2 busy; four 1..5 frames.
        src_q.delete();
        for (int f = 0; f < 4; f++)
            for (int i = 1; i <= 5; i++) src_q.push_back({1'b0, i == 1, i == 5, W'(i)});
        run_stream(2, 0, 400, mx, gaps);

        // Asynchronous reset mid-operation with three words held.
        step();
        dc_sflags = 2'b01;
        for (int i = 0; i < 3; i++) begin
            uc_d0 = W'(16'h0A0 + i);
            uc_mflags = 4'b0001;
            step();
        end
        uc_mflags = 4'b0;
        @(negedge clk);
        chk("pre_rst_lvl", lvl, 3'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mflags", cd_mflags, 4'b0);
        chk("async_rst_d0", cd_d0, 16'h0);
        chk("async_rst_lvl", lvl, 3'd0);
        chk("async_rst_cu", cu_sflags, 2'b00);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        dc_sflags = 2'b00;
        step();

        // Random traffic with upstream gaps and random consumer busy.
        src_q.delete();
        for (int i = 0; i < 60; i++)
            src_q.push_back({1'($urandom), 1'($urandom), (i == 59) || ($urandom_range(5) == 0),
                             W'($urandom)});
        run_stream(3, 25, 2000, mx, gaps);

`ifdef STREAM_FIFO_PKT_EN
        // Store-and-forward: nothing leaves until the frame end is held.
        step();
        rcv_q.delete();
        for (int i = 0; i < 4; i++) begin
            uc_d0 = W'(16'h100 + i);
            uc_mflags = {2'b00, i == 3, 1'b1};
            @(negedge clk);
            chk("pkt_hold_v", cd_mflags[0], 1'b0);
            step();
        end
        uc_mflags = 4'b0;
        @(negedge clk);
        chk("pkt_release_v", cd_mflags[0], 1'b1);
        repeat (6) step();
        chk("pkt_count", rcv_q.size(), 4);
        foreach (rcv_q[i]) chk("pkt_word", rcv_q[i][W-1:0], 16'h100 + i);

        // Frame longer than DEPTH cuts through once full.
        src_q.delete();
        for (int i = 1; i <= 6; i++) src_q.push_back({1'b0, i == 1, i == 6, W'(16'h200 + i)});
        run_stream(0, 0, 200, mx, gaps);
`endif

        repeat (3) step();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous first-word-fall-through FIFO stage for the stream pipeline. It sits directly downstream of any producing stage (gen_seq, sum_2, mul_2, delay, sum_reduce, …) and absorbs the consumer's busy bursts without stalling the producer until DEPTH words are held. Data and the A/F/L side flags are carried unchanged and in order. The stage speaks the standard uc_/cu_/cd_/dc_ master/slave flag protocol on both sides.

## Interface
- W, 16, data width
- DEPTH, 4, number of entries; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width; derived, not overridden

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- uc_d0  in  W  upstream data
- uc_mflags  in  4  upstream master flags {A,F,L,V}: bit3 A, bit2 F (first), bit1 L (last), bit0 V (valid)
- cu_sflags  out  2  slave flags to upstream: bit0 BSY, bit1 always 0
- cd_d0  out  W  downstream data (head entry)
- cd_mflags  out  4  downstream master flags {A,F,L,V}
- dc_sflags  in  2  slave flags from downstream: bit0 BSY; bit1 ignored
- lvl  out  AW+1  current occupancy, 0..DEPTH

Clock is clk; reset is rst_n, asynchronous and active-low.

## Operation
- Storage: DEPTH entries of {A,F,L,data} (W+3 bits); V is not stored, it is regenerated.
- Push: at a rising edge with uc_mflags[0]=1 and cu_sflags[0]=0, write {A,F,L,uc_d0} at wr_ptr; wr_ptr wraps mod DEPTH.
- Pop: at a rising edge with cd_mflags[0]=1 and dc_sflags[0]=0, advance rd_ptr mod DEPTH.
- Occupancy register cnt: +1 on push only, −1 on pop only, unchanged on both or neither. lvl = cnt.
- cu_sflags[0] = (cnt == DEPTH). No push occurs while full, even if a pop happens in the same cycle.
- cd_mflags[0] = (cnt != 0) in the default build. cd_mflags[3:1] and cd_d0 show the head entry when V=1, and are forced to 0 when V=0.
- Empty with a push: there is no same-cycle bypass. The word appears on cd the next cycle.
- Upstream words with V=0 are ignored; flags on those words have no effect.
- The A flag has no special meaning here; it is stored and forwarded like F/L.
- No overflow or underflow is possible by construction. The BSY/V gating is the only protection.
- Reset values: cnt=0, wr_ptr=0, rd_ptr=0, cu_sflags=2'b00, cd_mflags=4'b0000, cd_d0=0, lvl=0. Memory contents are don't-care.
- Reset mid-operation discards all held words immediately (asynchronously). Nothing is replayed after release.

## Timing
- Latency: a word pushed at edge N is visible on cd_d0/cd_mflags after edge N (cycle N+1) when the FIFO was empty.
- Throughput: 1 word/cycle sustained when downstream is not busy; cnt stays ≤ 1 under a continuous stream.
- BSY to upstream asserts the cycle after the push that fills the FIFO. It deasserts the cycle after the first pop from full.
- Downstream BSY is sampled at the edge only; cd holds its word stable while dc_sflags[0]=1.
- All outputs derive from registers (cnt, pointers, memory) through at most a read mux. There is no combinational path from uc_* or dc_* to any output.

## Configuration
- STREAM_FIFO_PKT_EN: packet (store-and-forward) mode.
- Defined:
  - A frame counter fcnt (AW+1 bits) increments on a push with L=1 and decrements on a pop with L=1; both in one cycle leaves it unchanged.
  - cd_mflags[0] = (cnt != 0) && (fcnt != 0 || cnt == DEPTH). The full override releases frames longer than DEPTH in cut-through fashion and prevents deadlock.
  - fcnt resets to 0.
- Undefined: no frame counter; plain FWFT behaviour as above.

## Test plan
- Latency: FIFO empty, push one word 16'h00AA with F=1, L=1 → next cycle cd_mflags=4'b0111, cd_d0=16'h00AA, lvl=1. Pop → lvl=0, cd_mflags=0.
- Fill/back-pressure: DEPTH=4, dc BSY=1, offer 1..5 → cu BSY=1 after the 4th push, lvl=4, word 5 held upstream. Drop dc BSY → cd emits 1,2,3,4,5 on consecutive cycles, and cu BSY clears one cycle after the first pop.
- Streaming: continuous 1..20 with dc BSY=0 → output 1..20 with no gaps, lvl never exceeds 1.
- Bursty consumer: gen_seq 1..5 frames (F on 1, L on 5) feeding the FIFO, dc BSY pattern 10 cycles low / 2 high → output sequence and F/L positions identical to input, no loss or duplication.
- Reset mid-operation: lvl=3, drive rst_n low between edges → cd_mflags=0, cd_d0=0, lvl=0, cu_sflags=0 without waiting for a clock edge. After release, the FIFO accepts new data normally.
- Packet mode (STREAM_FIFO_PKT_EN, DEPTH=4):
  - Push 3 words with L=0 → cd V stays 0. Push a 4th word with L=1 → V=1 next cycle and 4 words drain.
  - A 6-word frame with dc BSY=0 → V=1 once full, and all 6 words are delivered in order.
